alu_rs_scheduler: RTL and testbench



---
 rtl/alu_rs_scheduler_pkg.sv | 59 +++++
 rtl/alu_rs_scheduler_pick.sv | 21 ++
 rtl/alu_rs_scheduler.sv | 162 ++++++++++++++++
 tb/tb_alu_rs_scheduler.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_scheduler_pkg.sv
// Shared widths, opcode encoding, entry layout and CDB capture helper for the
// ALU reservation station.
package alu_rs_scheduler_pkg;

  localparam int OP_LOG  = 5;
  localparam int ROB_LOG = 4;

  typedef enum logic [OP_LOG-1:0] {
    OP_NOP  = 5'd0,
    OP_ADD  = 5'd1,
    OP_SUB  = 5'd2,
    OP_ADDI = 5'd3,
    OP_BEQ  = 5'd4,
    OP_JAL  = 5'd5
  } op_e;

  typedef struct packed {
    logic               busy;
    logic [OP_LOG-1:0]  op;
    logic [31:0]        vj;
    logic [31:0]        vk;
    logic               qj_busy;
    logic               qk_busy;
    logic [ROB_LOG-1:0] qj;
    logic [ROB_LOG-1:0] qk;
    logic [31:0]        imm;
    logic [31:0]        cur_pc;
    logic [ROB_LOG-1:0] dest_rob;
  } rs_entry_t;

  typedef struct packed {
    logic        busy;
    logic [31:0] val;
  } opnd_t;

  // Resolve one pending operand against both CDBs; CDB 0 takes precedence.
  function automatic opnd_t cdb_capture(
    input logic               q_busy,
    input logic [ROB_LOG-1:0] q,
    input logic [31:0]        v,
    input logic               c0_en,
    input logic [ROB_LOG-1:0] c0_id,
    input logic [31:0]        c0_val,
    input logic               c1_en,
    input logic [ROB_LOG-1:0] c1_id,
    input logic [31:0]        c1_val
  );
    opnd_t r;
    if (q_busy && c0_en && (c0_id == q)) begin
      r = '{busy: 1'b0, val: c0_val};
    end else if (q_busy && c1_en && (c1_id == q)) begin
      r = '{busy: 1'b0, val: c1_val};
    end else begin
      r = '{busy: q_busy, val: v};
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_scheduler_pick.sv
// Lowest-index priority encoder: request vector to index plus found flag.
module rs_pick #(
  parameter int N   = 16,
  parameter int LOG = 4
) (
  input  logic [N-1:0]   req,
  output logic [LOG-1:0] idx,
  output logic           found
);

  // Scan from the top so the lowest set request wins last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      idx   = req[i] ? LOG'(i) : idx;
      found = found | req[i];
    end
  end

endmodule

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: holds dispatched micro-ops until operands arrive
// from the CDBs and issues the lowest-index ready entry each cycle.
module alu_rs_scheduler
  import alu_rs_scheduler_pkg::*;
#(
  parameter int RS_SIZE = 16,
  parameter int RS_LOG  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rdy,
  input  logic               flush,
  input  logic               D_valid,
  input  logic [OP_LOG-1:0]  D_op,
  input  logic [31:0]        D_Vj,
  input  logic [31:0]        D_Vk,
  input  logic               D_Qj_busy,
  input  logic               D_Qk_busy,
  input  logic [ROB_LOG-1:0] D_Qj,
  input  logic [ROB_LOG-1:0] D_Qk,
  input  logic [31:0]        D_Imm,
  input  logic [31:0]        D_CurPC,
  input  logic [ROB_LOG-1:0] D_DestRob,
  output logic               full,
  input  logic               C0_enable,
  input  logic [ROB_LOG-1:0] C0_RobId,
  input  logic [31:0]        C0_value,
  input  logic               C1_enable,
  input  logic [ROB_LOG-1:0] C1_RobId,
  input  logic [31:0]        C1_value,
  output logic               RS_valid,
  output logic [OP_LOG-1:0]  RS_op,
  output logic [31:0]        RS_Vj,
  output logic [31:0]        RS_Vk,
  output logic [31:0]        RS_Imm,
  output logic [31:0]        RS_CurPC,
  output logic [ROB_LOG-1:0] RS_DestRob
);

  rs_entry_t [RS_SIZE-1:0] ent_r;
  rs_entry_t [RS_SIZE-1:0] ent_nxt_s;
  rs_entry_t               disp_ent_s;
  logic [RS_SIZE-1:0]      busy_s;
  logic [RS_SIZE-1:0]      ready_s;
  logic [RS_LOG-1:0]       free_idx_s;
  logic [RS_LOG-1:0]       issue_idx_s;
  logic                    free_found_s;
  logic                    issue_found_s;
  logic                    disp_s;

  logic                    rs_valid_r;
  logic [OP_LOG-1:0]       rs_op_r;
  logic [31:0]             rs_vj_r;
  logic [31:0]             rs_vk_r;
  logic [31:0]             rs_imm_r;
  logic [31:0]             rs_pc_r;
  logic [ROB_LOG-1:0]      rs_dest_r;

  // Occupancy and eligibility vectors from registered state only.
  always_comb begin
    busy_s  = '0;
    ready_s = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_s[i]  = ent_r[i].busy;
      ready_s[i] = ent_r[i].busy & ~ent_r[i].qj_busy & ~ent_r[i].qk_busy;
    end
  end

  assign full = &busy_s;

  rs_pick #(.N(RS_SIZE), .LOG(RS_LOG)) u_free_pick (
    .req   (~busy_s),
    .idx   (free_idx_s),
    .found (free_found_s)
  );

  rs_pick #(.N(RS_SIZE), .LOG(RS_LOG)) u_issue_pick (
    .req   (ready_s),
    .idx   (issue_idx_s),
    .found (issue_found_s)
  );

  assign disp_s = D_valid && free_found_s && (D_op != OP_NOP);

  // Build the incoming entry, snooping both CDBs for its pending operands.
  always_comb begin
    disp_ent_s          = '0;
    disp_ent_s.busy     = 1'b1;
    disp_ent_s.op       = D_op;
    disp_ent_s.qj       = D_Qj;
    disp_ent_s.qk       = D_Qk;
    disp_ent_s.imm      = D_Imm;
    disp_ent_s.cur_pc   = D_CurPC;
    disp_ent_s.dest_rob = D_DestRob;
    {disp_ent_s.qj_busy, disp_ent_s.vj} = cdb_capture(D_Qj_busy, D_Qj, D_Vj,
        C0_enable, C0_RobId, C0_value, C1_enable, C1_RobId, C1_value);
    {disp_ent_s.qk_busy, disp_ent_s.vk} = cdb_capture(D_Qk_busy, D_Qk, D_Vk,
        C0_enable, C0_RobId, C0_value, C1_enable, C1_RobId, C1_value);
  end

  // Per-entry next state: a free slot never issues, an issuing slot needs no wakeup.
  always_comb begin
    ent_nxt_s = ent_r;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (disp_s && (free_idx_s == RS_LOG'(i))) begin
        ent_nxt_s[i] = disp_ent_s;
      end else if (issue_found_s && (issue_idx_s == RS_LOG'(i))) begin
        ent_nxt_s[i].busy = 1'b0;
      end else if (ent_r[i].busy) begin
        {ent_nxt_s[i].qj_busy, ent_nxt_s[i].vj} = cdb_capture(ent_r[i].qj_busy,
            ent_r[i].qj, ent_r[i].vj, C0_enable, C0_RobId, C0_value,
            C1_enable, C1_RobId, C1_value);
        {ent_nxt_s[i].qk_busy, ent_nxt_s[i].vk} = cdb_capture(ent_r[i].qk_busy,
            ent_r[i].qk, ent_r[i].vk, C0_enable, C0_RobId, C0_value,
            C1_enable, C1_RobId, C1_value);
      end else begin
        ent_nxt_s[i].busy = 1'b0;
      end
    end
  end

  // Entry storage and issue registers; flush beats freeze beats normal update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_r      <= '0;
      rs_valid_r <= 1'b0;
      rs_op_r    <= '0;
      rs_vj_r    <= 32'd0;
      rs_vk_r    <= 32'd0;
      rs_imm_r   <= 32'd0;
      rs_pc_r    <= 32'd0;
      rs_dest_r  <= '0;
    end else if (flush) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_r[i].busy <= 1'b0;
      end
      rs_valid_r <= 1'b0;
    end else if (!rdy) begin
      rs_valid_r <= 1'b0;
    end else begin
      ent_r      <= ent_nxt_s;
      rs_valid_r <= issue_found_s;
      if (issue_found_s) begin
        rs_op_r   <= ent_r[issue_idx_s].op;
        rs_vj_r   <= ent_r[issue_idx_s].vj;
        rs_vk_r   <= ent_r[issue_idx_s].vk;
        rs_imm_r  <= ent_r[issue_idx_s].imm;
        rs_pc_r   <= ent_r[issue_idx_s].cur_pc;
        rs_dest_r <= ent_r[issue_idx_s].dest_rob;
      end
    end
  end

  assign RS_valid   = rs_valid_r;
  assign RS_op      = rs_op_r;
  assign RS_Vj      = rs_vj_r;
  assign RS_Vk      = rs_vk_r;
  assign RS_Imm     = rs_imm_r;
  assign RS_CurPC   = rs_pc_r;
  assign RS_DestRob = rs_dest_r;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed bench for alu_rs_scheduler: expected issues are queued with the
// cycle they must appear in and checked against the DUT each cycle.
module tb_alu_rs_scheduler;
  import alu_rs_scheduler_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n, rdy, flush;
  logic               D_valid, D_Qj_busy, D_Qk_busy;
  logic [OP_LOG-1:0]  D_op;
  logic [31:0]        D_Vj, D_Vk, D_Imm, D_CurPC;
  logic [ROB_LOG-1:0] D_Qj, D_Qk, D_DestRob;
  logic               full;
  logic               C0_enable, C1_enable;
  logic [ROB_LOG-1:0] C0_RobId, C1_RobId;
  logic [31:0]        C0_value, C1_value;
  logic               RS_valid;
  logic [OP_LOG-1:0]  RS_op;
  logic [31:0]        RS_Vj, RS_Vk, RS_Imm, RS_CurPC;
  logic [ROB_LOG-1:0] RS_DestRob;

  always #5 clk = ~clk;

  alu_rs_scheduler dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .D_valid(D_valid), .D_op(D_op), .D_Vj(D_Vj), .D_Vk(D_Vk),
    .D_Qj_busy(D_Qj_busy), .D_Qk_busy(D_Qk_busy), .D_Qj(D_Qj), .D_Qk(D_Qk),
    .D_Imm(D_Imm), .D_CurPC(D_CurPC), .D_DestRob(D_DestRob), .full(full),
    .C0_enable(C0_enable), .C1_enable(C1_enable),
    .C0_RobId(C0_RobId), .C1_RobId(C1_RobId),
    .C0_value(C0_value), .C1_value(C1_value),
    .RS_valid(RS_valid), .RS_op(RS_op), .RS_Vj(RS_Vj), .RS_Vk(RS_Vk),
    .RS_Imm(RS_Imm), .RS_CurPC(RS_CurPC), .RS_DestRob(RS_DestRob)
  );

  typedef struct {
    int                 cyc;
    logic [OP_LOG-1:0]  op;
    logic [31:0]        vj, vk, imm, pc;
    logic [ROB_LOG-1:0] dest;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock edge; then compare the issue port with the scoreboard head.
  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("rs_valid", 32'(RS_valid), 32'd1);
      chk("rs_op", 32'(RS_op), 32'(e.op));
      chk("rs_vj", RS_Vj, e.vj);
      chk("rs_vk", RS_Vk, e.vk);
      chk("rs_imm", RS_Imm, e.imm);
      chk("rs_pc", RS_CurPC, e.pc);
      chk("rs_dest", 32'(RS_DestRob), 32'(e.dest));
    end else begin
      chk("rs_idle", 32'(RS_valid), 32'd0);
    end
  endtask

  task automatic expect_issue(input int at, input logic [OP_LOG-1:0] op,
                              input logic [31:0] vj, input logic [31:0] vk,
                              input logic [31:0] imm, input logic [31:0] pc,
                              input logic [ROB_LOG-1:0] dest);
    exp_t e;
    e.cyc = at; e.op = op; e.vj = vj; e.vk = vk; e.imm = imm; e.pc = pc; e.dest = dest;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    D_valid = 1'b0; D_op = OP_NOP; D_Vj = 32'd0; D_Vk = 32'd0;
    D_Qj_busy = 1'b0; D_Qk_busy = 1'b0; D_Qj = 4'd0; D_Qk = 4'd0;
    D_Imm = 32'd0; D_CurPC = 32'd0; D_DestRob = 4'd0;
    C0_enable = 1'b0; C0_RobId = 4'd0; C0_value = 32'd0;
    C1_enable = 1'b0; C1_RobId = 4'd0; C1_value = 32'd0;
  endtask

  task automatic drive_disp(input logic [OP_LOG-1:0] op, input logic [31:0] vj,
                            input logic [31:0] vk, input logic qjb,
                            input logic [ROB_LOG-1:0] qj, input logic qkb,
                            input logic [ROB_LOG-1:0] qk, input logic [31:0] imm,
                            input logic [31:0] pc, input logic [ROB_LOG-1:0] dest);
    D_valid = 1'b1; D_op = op; D_Vj = vj; D_Vk = vk;
    D_Qj_busy = qjb; D_Qj = qj; D_Qk_busy = qkb; D_Qk = qk;
    D_Imm = imm; D_CurPC = pc; D_DestRob = dest;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
    idle_inputs();

    // Reset state
    step(); step();
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_vj", RS_Vj, 32'd0);
    chk("reset_imm", RS_Imm, 32'd0);
    chk("reset_dest", 32'(RS_DestRob), 32'd0);
    rst_n = 1'b1;
    step();

    // Ready ADDI issues one edge after dispatch, single pulse
    drive_disp(OP_ADDI, 32'd5, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd7, 32'h100, 4'd2);
    expect_issue(cyc + 2, OP_ADDI, 32'd5, 32'd0, 32'd7, 32'h100, 4'd2);
    step(); idle_inputs();
    step(); step();

    // Qj pending on tag 3, woken by CDB 1 two cycles after dispatch
    drive_disp(OP_ADD, 32'hDEAD, 32'd4, 1'b1, 4'd3, 1'b0, 4'd0, 32'd0, 32'h104, 4'd4);
    step(); idle_inputs();
    step();
    C1_enable = 1'b1; C1_RobId = 4'd3; C1_value = 32'h10;
    expect_issue(cyc + 2, OP_ADD, 32'h10, 32'd4, 32'd0, 32'h104, 4'd4);
    step(); idle_inputs();
    step(); step();

    // Qk captured from CDB 0 in the dispatch cycle
    drive_disp(OP_SUB, 32'd1, 32'hBEEF, 1'b0, 4'd0, 1'b1, 4'd6, 32'd0, 32'h108, 4'd5);
    C0_enable = 1'b1; C0_RobId = 4'd6; C0_value = 32'd9;
    expect_issue(cyc + 2, OP_SUB, 32'd1, 32'd9, 32'd0, 32'h108, 4'd5);
    step(); idle_inputs();
    step(); step();

    // Fill all 16 entries blocked on tag 1
    for (int i = 0; i < 16; i++) begin
      drive_disp(OP_ADD, 32'd0, 32'(i), 1'b1, 4'd1, 1'b0, 4'd0, 32'(i), 32'h200 + 32'(4 * i), 4'(i));
      step();
      if (i == 14) chk("full_at_15", 32'(full), 32'd0);
    end
    chk("full_at_16", 32'(full), 32'd1);
    drive_disp(OP_SUB, 32'd3, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'h2FC, 4'd15);
    step(); idle_inputs();
    chk("full_after_drop", 32'(full), 32'd1);
    C0_enable = 1'b1; C0_RobId = 4'd1; C0_value = 32'hAB;
    for (int i = 0; i < 16; i++) begin
      expect_issue(cyc + 2 + i, OP_ADD, 32'hAB, 32'(i), 32'(i), 32'h200 + 32'(4 * i), 4'(i));
    end
    step(); idle_inputs();
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 0) chk("full_after_issue", 32'(full), 32'd0);
    end
    step();

    // Flush with 4 busy entries and a concurrent dispatch and broadcast
    for (int i = 0; i < 4; i++) begin
      drive_disp(OP_ADD, 32'd0, 32'd0, 1'b1, 4'd5, 1'b0, 4'd0, 32'd0, 32'h400, 4'(8 + i));
      step();
    end
    flush = 1'b1;
    drive_disp(OP_ADDI, 32'd1, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd1, 32'h410, 4'd1);
    C0_enable = 1'b1; C0_RobId = 4'd5; C0_value = 32'h55;
    step(); flush = 1'b0; idle_inputs();
    chk("full_after_flush", 32'(full), 32'd0);
    C0_enable = 1'b1; C0_RobId = 4'd5; C0_value = 32'h55;
    step(); idle_inputs();
    step(); step(); step();

    // Freeze: no issue, no wakeup while rdy is low
    drive_disp(OP_ADD, 32'd0, 32'd2, 1'b1, 4'd7, 1'b0, 4'd0, 32'd0, 32'h500, 4'd12);
    step();
    drive_disp(OP_ADDI, 32'h33, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd1, 32'h504, 4'd13);
    step(); idle_inputs();
    rdy = 1'b0;
    C1_enable = 1'b1; C1_RobId = 4'd7; C1_value = 32'h77;
    step(); step(); step();
    chk("full_frozen", 32'(full), 32'd0);
    rdy = 1'b1; idle_inputs();
    expect_issue(cyc + 1, OP_ADDI, 32'h33, 32'd0, 32'd1, 32'h504, 4'd13);
    step(); step();
    C0_enable = 1'b1; C0_RobId = 4'd7; C0_value = 32'h99;
    expect_issue(cyc + 2, OP_ADD, 32'h99, 32'd2, 32'd0, 32'h500, 4'd12);
    step(); idle_inputs();
    step(); step();

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
